axi_master_wr: RTL and testbench
================================

AXI_MASTER_WR -- requirements
Module: axi_master_wr

Interface
REQ-001 SHALL have parameter AXI_ID_W, default 4: width of the AXI ID fields.
REQ-002 SHALL have parameter AXI_ID, default 0: constant driven on m_axi_awid.
REQ-003 SHALL have port clk  in  1: AXI master clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port wr_start  in  1: burst request from the controller; level, held until wr_ready falls.
REQ-006 SHALL have port wr_addr  in  30: byte start address of the burst.
REQ-007 SHALL have port wr_len  in  8: AXI burst length (beats - 1).
REQ-008 SHALL have port wr_data  in  64: write data from a first-word-fall-through write FIFO.
REQ-009 SHALL have port wr_ready  out  1: master idle and able to accept wr_start.
REQ-010 SHALL have port wr_writing  out  1: FIFO read enable; one word consumed per high cycle.
REQ-011 SHALL have port wr_done  out  1: one-cycle pulse marking burst completion.
REQ-012 SHALL have port wr_err  out  1: sticky bad-response flag.
REQ-013 SHALL have AW channel ports: m_axi_awid (AXI_ID_W), awaddr (30), awlen (8), awsize (3), awburst (2), awvalid (out), awready (in).
REQ-014 SHALL have W channel ports: m_axi_wdata (64), wstrb (8), wlast (out), wvalid (out), wready (in).
REQ-015 SHALL have B channel ports: m_axi_bid (AXI_ID_W, in), bresp (2, in), bvalid (in), bready (out).

Function
REQ-016 SHALL implement FSM IDLE -> AW -> W -> B -> IDLE, with bursts strictly sequential (W starts only after the AW handshake).
REQ-017 SHALL drive wr_ready = (state == IDLE), combinationally.
REQ-018 In IDLE, wr_start=1 SHALL latch wr_addr/wr_len into awaddr/awlen, set awvalid=1 and enter AW.
REQ-019 wr_start SHALL be ignored in every other state.
REQ-020 In AW, awvalid SHALL hold with stable payload until awready; on the handshake, awvalid=0, wvalid=1, beat counter=0, enter W.
REQ-021 In W, wdata SHALL equal wr_data combinationally.
REQ-022 wr_writing SHALL equal wvalid & wready.
REQ-023 The beat counter SHALL increment on each wvalid & wready.
REQ-024 wlast SHALL equal wvalid & (counter == awlen); wr_len=0 therefore gives wlast on the first beat.
REQ-025 A handshake with wlast SHALL clear wvalid, set bready=1 and enter B.
REQ-026 In B, a bvalid & bready cycle SHALL clear bready, return to IDLE and make wr_done=1 for exactly the next cycle.
REQ-027 Constant outputs SHALL be: awsize=3'b011 (8 bytes), awburst=2'b01 (INCR), wstrb=8'hFF, awid=AXI_ID.
REQ-028 The block SHALL NOT check 4 KB boundary crossings or end-address wrap; the upstream controller owns these.
REQ-029 A stalled wready (low) SHALL hold wvalid, wdata, wlast and the counter, with wr_writing=0.
REQ-030 bid SHALL be ignored.

Reset
REQ-031 rst_n low SHALL immediately set state=IDLE and awvalid=wvalid=bready=wr_done=wr_err=0, counter=0, awaddr=0, awlen=0; this holds mid-burst, with no resumption.
REQ-032 After reset release, wr_ready SHALL be 1 in the first cycle.

Configuration
REQ-033 With macro AXI_WR_RESP_CHK_EN defined, a B handshake with bresp = 2'b10 or 2'b11 SHALL set wr_err, cleared only by reset.
REQ-034 Without AXI_WR_RESP_CHK_EN, wr_err SHALL be tied 0 and bresp ignored.

Structure
REQ-035 Package axi_wr_pkg SHALL hold the FSM state enum, AXI_SIZE_8B, AXI_BURST_INCR, AXI_RESP_OKAY/SLVERR/DECERR.
REQ-036 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-037 Nominal: wr_addr=0x100, wr_len=15, awready/wready always 1 -> awaddr=0x100, awlen=15, 16 wr_writing cycles, wlast on beat 16, wr_done 1 cycle after B.
REQ-038 Single beat: wr_len=0 -> one beat with wlast=1, wr_writing high 1 cycle.
REQ-039 Backpressure: awready delayed 5 cycles, wready toggling 50%, wr_len=7 -> awaddr/awlen stable while waiting, exactly 8 wr_writing cycles, data order preserved.
REQ-040 Busy request: wr_start held through a burst -> no second AW before wr_done; second burst starts ≥1 cycle after wr_done.
REQ-041 Mid-burst reset at beat 3 of 16 -> all valids 0 immediately, wr_ready=1 after release.
REQ-042 bresp=2'b10 -> wr_err=1 sticky with AXI_WR_RESP_CHK_EN defined, 0 without it.

Source files
------------

// File: rtl/axi_wr_pkg.sv
// Shared types and AXI constants for the AXI write-burst master.
package axi_wr_pkg;

  // Burst sequencer states: address phase, data phase, response phase.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_t;

  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // SLVERR and DECERR both have bit 1 set; EXOKAY/OKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_master_wr.sv
// AXI4 write-burst master: one INCR burst of 64-bit beats per wr_start,
// AW, W and B phases strictly in sequence. Write data is taken straight
// from a first-word-fall-through FIFO; wr_writing pops it.
// Optional macro AXI_WR_RESP_CHK_EN: latch a sticky wr_err on SLVERR/DECERR.
module axi_master_wr
  import axi_wr_pkg::*;
#(
  parameter int AXI_ID_W = 4,
  parameter int AXI_ID   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  // controller side
  input  logic                wr_start,
  input  logic [29:0]         wr_addr,
  input  logic [7:0]          wr_len,
  input  logic [63:0]         wr_data,
  output logic                wr_ready,
  output logic                wr_writing,
  output logic                wr_done,
  output logic                wr_err,
  // AW channel
  output logic [AXI_ID_W-1:0] m_axi_awid,
  output logic [29:0]         m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  // W channel
  output logic [63:0]         m_axi_wdata,
  output logic [7:0]          m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  // B channel
  input  logic [AXI_ID_W-1:0] m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
);

  wr_state_t   state, state_nxt;
  logic [29:0] awaddr_q;
  logic [7:0]  awlen_q;
  logic [7:0]  beat_cnt;
  logic        done_q;
  logic        aw_hs, w_hs, b_hs;

  // Channel valids/readies are pure state decodes, so they drop the
  // instant reset forces the state back to IDLE.
  assign m_axi_awvalid = (state == ST_AW);
  assign m_axi_wvalid  = (state == ST_W);
  assign m_axi_bready  = (state == ST_B);
  assign wr_ready      = (state == ST_IDLE);

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid  & m_axi_wready;
  assign b_hs  = m_axi_bvalid  & m_axi_bready;

  assign m_axi_awid    = AXI_ID_W'(AXI_ID);
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = AXI_SIZE_8B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = 8'hFF;
  assign m_axi_wlast   = m_axi_wvalid & (beat_cnt == awlen_q);
  assign wr_writing    = w_hs;
  assign wr_done       = done_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one burst at a time, wr_start only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (wr_start)           state_nxt = ST_AW;
      ST_AW:   if (aw_hs)              state_nxt = ST_W;
      ST_W:    if (w_hs && m_axi_wlast) state_nxt = ST_B;
      ST_B:    if (b_hs)               state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  // Capture the burst descriptor on acceptance; it stays stable until the
  // next accepted request. No 4 KB or wrap checks: the controller owns that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr_q <= '0;
      awlen_q  <= '0;
    end else if (wr_ready && wr_start) begin
      awaddr_q <= wr_addr;
      awlen_q  <= wr_len;
    end
  end

  // Beat counter: cleared at the AW handshake, advanced per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     beat_cnt <= '0;
    else if (aw_hs) beat_cnt <= '0;
    else if (w_hs)  beat_cnt <= beat_cnt + 8'd1;
  end

  // Completion pulse in the cycle right after the B handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= b_hs;
  end

`ifdef AXI_WR_RESP_CHK_EN
  logic err_q;

  // Sticky error on a bad write response; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              err_q <= 1'b0;
    else if (b_hs && resp_is_err(m_axi_bresp)) err_q <= 1'b1;
  end

  assign wr_err = err_q;

  logic unused_b;
  assign unused_b = ^m_axi_bid;
`else
  assign wr_err = 1'b0;

  logic unused_b;
  assign unused_b = ^{m_axi_bid, m_axi_bresp};
`endif

endmodule

// File: tb/tb_axi_master_wr.sv
// Randomized bench for axi_master_wr: burst-level reference model on the
// negative edge, random AXI slave handshakes, directed reset checks.
module tb_axi_master_wr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_start = 1'b0;
  logic [29:0] wr_addr = '0;
  logic [7:0]  wr_len = '0;
  logic [63:0] wr_data;
  logic        wr_ready, wr_writing, wr_done, wr_err;
  logic [3:0]  awid;
  logic [29:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid;
  logic        wready = 1'b0;
  logic [3:0]  bid = '0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;

  int checks = 0;
  int failures = 0;

  axi_master_wr #(.AXI_ID_W(4), .AXI_ID(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_writing(wr_writing), .wr_done(wr_done), .wr_err(wr_err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // FWFT FIFO contents: word i is a fixed function of i.
  function automatic logic [63:0] fifo_word(input int unsigned i);
    return {32'hC0DE0000 ^ i, i * 32'h9E3779B9};
  endfunction

  int unsigned rd_idx = 0;
  assign wr_data = fifo_word(rd_idx);
  always @(posedge clk) if (wr_writing) rd_idx <= rd_idx + 1;

  // Slave behaviour knobs
  bit rnd_en = 1'b0;
  int aw_pct = 100, w_pct = 100, b_pct = 100;
  bit force_slverr = 1'b0;

  // random slave handshakes, updated just after each rising edge
  initial forever begin
    @(posedge clk); #1;
    if (rnd_en) begin
      awready = ($urandom_range(99) < aw_pct);
      wready  = ($urandom_range(99) < w_pct);
      bvalid  = ($urandom_range(99) < b_pct);
      bresp   = force_slverr ? 2'b10 : 2'($urandom_range(3));
      bid     = 4'($urandom);
    end
  end

  // Reference model: what the master owes the bus for the burst in flight.
  bit          mon_en = 1'b0;
  bit          busy = 0, aw_done = 0, w_done = 0;
  bit          exp_done = 0, exp_err = 0;
  logic [29:0] cur_addr;
  logic [7:0]  cur_len;
  int          beat = 0;
  int unsigned exp_idx = 0;
  int          bursts = 0;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      bit aw_ph, w_ph, b_ph;
      aw_ph = busy && !aw_done;
      w_ph  = busy && aw_done && !w_done;
      b_ph  = busy && w_done;
      chk("wr_done", wr_done, exp_done);
      chk("wr_err", wr_err, exp_err);
      chk("wr_ready", wr_ready, !busy);
      chk("awvalid", awvalid, aw_ph);
      chk("wvalid", wvalid, w_ph);
      chk("bready", bready, b_ph);
      chk("wr_writing", wr_writing, w_ph && wready);
      if (aw_ph) begin
        chk("awaddr", awaddr, cur_addr);
        chk("awlen", awlen, cur_len);
        chk("awsize", awsize, 3'b011);
        chk("awburst", awburst, 2'b01);
        chk("awid", awid, 4'd0);
      end
      if (w_ph) begin
        chk("wlast", wlast, beat == int'(cur_len));
        chk("wdata", wdata, fifo_word(exp_idx));
        chk("wstrb", wstrb, 8'hFF);
      end
      // events that happen at the coming rising edge
      exp_done = 0;
      if (!busy) begin
        if (wr_start) begin
          busy = 1; aw_done = 0; w_done = 0; beat = 0;
          cur_addr = wr_addr; cur_len = wr_len;
        end
      end else if (aw_ph) begin
        if (awready) aw_done = 1;
      end else if (w_ph) begin
        if (wready) begin
          exp_idx++;
          if (beat == int'(cur_len)) w_done = 1;
          beat++;
        end
      end else if (bvalid) begin
        busy = 0;
        exp_done = 1;
        bursts++;
`ifdef AXI_WR_RESP_CHK_EN
        if (bresp[1]) exp_err = 1;
`endif
      end
    end
  end

  // one burst request; hold keeps wr_start high while the burst runs
  task automatic run_burst(input logic [29:0] a, input logic [7:0] l, input bit hold);
    int n;
    n = 0;
    while (!wr_ready && n < 3000) begin @(posedge clk); #1; n++; end
    if (!wr_ready) chk("idle_timeout", 0, 1);
    wr_addr = a; wr_len = l; wr_start = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      wr_start = 1'b0;
      wr_addr = 30'($urandom);   // later changes must not disturb awaddr
      wr_len  = 8'($urandom);
    end
    n = 0;
    while (!wr_done && n < 3000) begin @(posedge clk); #1; n++; end
    if (!wr_done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int beats;
    // reset state
    #12;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_awlen", awlen, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    chk("rel_wr_ready", wr_ready, 1);
    rnd_en = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // nominal 16-beat burst, no stalls
    aw_pct = 100; w_pct = 100; b_pct = 100; force_slverr = 0;
    run_burst(30'h100, 8'd15, 0);
    // single beat with a SLVERR response
    force_slverr = 1;
    run_burst(30'h2000, 8'd0, 0);
    force_slverr = 0;
    // backpressure on AW and W
    aw_pct = 20; w_pct = 50; b_pct = 60;
    run_burst(30'h3F00, 8'd7, 0);
    // wr_start held through the burst
    aw_pct = 100; w_pct = 100; b_pct = 100;
    run_burst(30'h400, 8'd3, 1);
    run_burst(30'h800, 8'd2, 0);
    // random bursts
    for (int i = 0; i < 30; i++) begin
      aw_pct = $urandom_range(20, 100);
      w_pct  = $urandom_range(20, 100);
      b_pct  = $urandom_range(20, 100);
      run_burst(30'($urandom), 8'($urandom_range(0, 31)), ($urandom_range(3) == 0) && i < 29);
    end
    wr_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("burst_count_min", bursts >= 35, 1);

    // mid-burst reset at beat 3 of 16
    mon_en = 1'b0;
    rnd_en = 1'b0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    run_start_for_reset: begin
      int n;
      n = 0;
      while (!wr_ready && n < 3000) begin @(posedge clk); #1; n++; end
      wr_addr = 30'h500; wr_len = 8'd15; wr_start = 1'b1;
      @(posedge clk); #1;
      wr_start = 1'b0;
      beats = 0; n = 0;
      while (beats < 3 && n < 100) begin
        @(negedge clk); n++;
        if (wr_writing) beats++;
      end
      chk("mid_beats", beats, 3);
    end
    @(posedge clk); #2;
    chk("mid_wvalid_before", wvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_awvalid", awvalid, 0);
    chk("mid_wvalid", wvalid, 0);
    chk("mid_bready", bready, 0);
    chk("mid_wr_writing", wr_writing, 0);
    chk("mid_wr_done", wr_done, 0);
    chk("mid_wr_err", wr_err, 0);
    chk("mid_awaddr", awaddr, 0);
    chk("mid_awlen", awlen, 0);
    chk("mid_wr_ready", wr_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_wr_ready", wr_ready, 1);
    chk("post_wvalid", wvalid, 0);
    @(posedge clk); #1;
    chk("post_no_resume", awvalid | wvalid | bready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
